// File: rtl/vga_timing_gen.sv
// Combined horizontal/vertical VGA timing generator with a frame-boundary
// reprogrammable timing set, programmable sync polarity and frame counter.
module vga_timing_gen #(
  parameter int W        = 12,
  parameter int FCW      = 16,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int H_POL    = 0,
  parameter int V_POL    = 0
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           enable,
  input  logic           cfg_valid,
  output logic           cfg_ready,
  input  logic [4*W-1:0] cfg_h,
  input  logic [4*W-1:0] cfg_v,
  input  logic [1:0]     cfg_pol,
  output logic           cfg_err,
  output logic           hsync,
  output logic           vsync,
  output logic           hactive,
  output logic           vactive,
  output logic           de,
  output logic [W-1:0]   x,
  output logic [W-1:0]   y,
  output logic           next_line,
  output logic           next_frame,
  output logic [FCW-1:0] frame_count
);

  typedef struct packed {
    logic [W-1:0] act;
    logic [W-1:0] fp;
    logic [W-1:0] sync;
    logic [W-1:0] bp;
  } axis_t;

  localparam logic [W+1:0]   MAX_TOT = {2'b01, {W{1'b0}}};
  localparam logic [W+1:0]   ONE_T   = {{(W+1){1'b0}}, 1'b1};
  localparam logic [W-1:0]   ONE_P   = {{(W-1){1'b0}}, 1'b1};
  localparam logic [FCW-1:0] ONE_F   = {{(FCW-1){1'b0}}, 1'b1};
  localparam axis_t DEF_H = '{act: W'(H_ACTIVE), fp: W'(H_FP), sync: W'(H_SYNC), bp: W'(H_BP)};
  localparam axis_t DEF_V = '{act: W'(V_ACTIVE), fp: W'(V_FP), sync: W'(V_SYNC), bp: W'(V_BP)};
  localparam logic  DEF_HPOL = 1'(H_POL);
  localparam logic  DEF_VPOL = 1'(V_POL);

  function automatic logic [W+1:0] ext(input logic [W-1:0] v);
    return {2'b00, v};
  endfunction

  function automatic logic [W+1:0] axis_total(input axis_t a);
    return ext(a.act) + ext(a.fp) + ext(a.sync) + ext(a.bp);
  endfunction

  // A legal axis has no zero-length field and a total that still fits a W-bit position.
  function automatic logic axis_legal(input axis_t a);
    return (a.act != {W{1'b0}}) && (a.fp != {W{1'b0}}) &&
           (a.sync != {W{1'b0}}) && (a.bp != {W{1'b0}}) &&
           (axis_total(a) <= MAX_TOT);
  endfunction

  logic [W-1:0] hpos, vpos;
  axis_t        live_h, live_v, shd_h, shd_v, new_h, new_v;
  logic         live_hpol, live_vpol, shd_hpol, shd_vpol, pending;
  logic [W+1:0] h_tot, v_tot, hs_start, hs_end, vs_start, vs_end;
  logic         h_last, v_last, hs_on, vs_on, cfg_fire, cfg_good;

  assign new_h    = cfg_h;
  assign new_v    = cfg_v;
  assign h_tot    = axis_total(live_h);
  assign v_tot    = axis_total(live_v);
  assign h_last   = (ext(hpos) == h_tot - ONE_T);
  assign v_last   = (ext(vpos) == v_tot - ONE_T);
  assign hs_start = ext(live_h.act) + ext(live_h.fp);
  assign hs_end   = hs_start + ext(live_h.sync);
  assign vs_start = ext(live_v.act) + ext(live_v.fp);
  assign vs_end   = vs_start + ext(live_v.sync);
  assign hs_on    = (ext(hpos) >= hs_start) && (ext(hpos) < hs_end);
  assign vs_on    = (ext(vpos) >= vs_start) && (ext(vpos) < vs_end);

  assign hactive    = (hpos < live_h.act);
  assign vactive    = (vpos < live_v.act);
  assign de         = hactive & vactive;
  assign x          = hactive ? hpos : {W{1'b0}};
  assign y          = vactive ? vpos : {W{1'b0}};
  assign hsync      = hs_on ^ ~live_hpol;
  assign vsync      = vs_on ^ ~live_vpol;
  assign next_line  = enable & h_last;
  assign next_frame = next_line & v_last;

  assign cfg_ready = ~pending;
  assign cfg_fire  = cfg_valid & ~pending;
  assign cfg_good  = axis_legal(new_h) & axis_legal(new_v);

  // Raster position and completed-frame counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hpos        <= {W{1'b0}};
      vpos        <= {W{1'b0}};
      frame_count <= {FCW{1'b0}};
    end else if (enable) begin
      if (h_last) begin
        hpos <= {W{1'b0}};
        if (v_last) begin
          vpos        <= {W{1'b0}};
          frame_count <= frame_count + ONE_F;
        end else begin
          vpos <= vpos + ONE_P;
        end
      end else begin
        hpos <= hpos + ONE_P;
      end
    end
  end

  // Config slot and live timing; a pending shadow set is promoted only at frame end.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      live_h    <= DEF_H;
      live_v    <= DEF_V;
      live_hpol <= DEF_HPOL;
      live_vpol <= DEF_VPOL;
      shd_h     <= DEF_H;
      shd_v     <= DEF_V;
      shd_hpol  <= DEF_HPOL;
      shd_vpol  <= DEF_VPOL;
      pending   <= 1'b0;
      cfg_err   <= 1'b0;
    end else begin
      cfg_err <= cfg_fire & ~cfg_good;
      if (next_frame && pending) begin
        live_h    <= shd_h;
        live_v    <= shd_v;
        live_hpol <= shd_hpol;
        live_vpol <= shd_vpol;
      end
      // A transfer needs pending==0, so it never collides with the promotion above.
      if (cfg_fire && cfg_good) begin
        shd_h    <= new_h;
        shd_v    <= new_v;
        shd_hpol <= cfg_pol[0];
        shd_vpol <= cfg_pol[1];
        pending  <= 1'b1;
      end else if (next_frame) begin
        pending <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: a default-parameter instance for line timing and a small-raster
// instance for frame-level reprogramming, reset and handshake behaviour.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // Default-parameter instance
  logic        rst_d, en_d;
  logic        cfg_valid_d = 1'b0;
  logic [47:0] cfg_h_d = 48'd0;
  logic [47:0] cfg_v_d = 48'd0;
  logic [1:0]  cfg_pol_d = 2'b00;
  logic        cfg_ready_d, cfg_err_d, hsync_d, vsync_d, hactive_d, vactive_d, de_d;
  logic [11:0] x_d, y_d;
  logic        nl_d, nf_d;
  logic [15:0] fc_d;

  vga_timing_gen dut_def (
    .clk(clk), .rst(rst_d), .enable(en_d),
    .cfg_valid(cfg_valid_d), .cfg_ready(cfg_ready_d),
    .cfg_h(cfg_h_d), .cfg_v(cfg_v_d), .cfg_pol(cfg_pol_d), .cfg_err(cfg_err_d),
    .hsync(hsync_d), .vsync(vsync_d), .hactive(hactive_d), .vactive(vactive_d),
    .de(de_d), .x(x_d), .y(y_d), .next_line(nl_d), .next_frame(nf_d),
    .frame_count(fc_d)
  );

  // Small-raster instance: 16 x 8 total, sync at h 10..12 and v 5..6
  logic        rst_s, en_s, cfg_valid_s;
  logic [47:0] cfg_h_s, cfg_v_s;
  logic [1:0]  cfg_pol_s;
  logic        cfg_ready_s, cfg_err_s, hsync_s, vsync_s, hactive_s, vactive_s, de_s;
  logic [11:0] x_s, y_s;
  logic        nl_s, nf_s;
  logic [15:0] fc_s;

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1)
  ) dut (
    .clk(clk), .rst(rst_s), .enable(en_s),
    .cfg_valid(cfg_valid_s), .cfg_ready(cfg_ready_s),
    .cfg_h(cfg_h_s), .cfg_v(cfg_v_s), .cfg_pol(cfg_pol_s), .cfg_err(cfg_err_s),
    .hsync(hsync_s), .vsync(vsync_s), .hactive(hactive_s), .vactive(vactive_s),
    .de(de_s), .x(x_s), .y(y_s), .next_line(nl_s), .next_frame(nf_s),
    .frame_count(fc_s)
  );

  localparam logic [47:0] SMALL_H = {12'd8, 12'd2, 12'd3, 12'd3};
  localparam logic [47:0] SMALL_V = {12'd4, 12'd1, 12'd2, 12'd1};
  localparam logic [47:0] BAD_H0  = {12'd8, 12'd2, 12'd0, 12'd3};
  localparam logic [47:0] BAD_BIG = {12'd4000, 12'd50, 12'd50, 12'd50};
  localparam logic [47:0] MIN_A   = {12'd1, 12'd1, 12'd1, 12'd1};
  localparam logic [47:0] B_H     = {12'd6, 12'd1, 12'd2, 12'd1};
  localparam logic [47:0] B_V     = {12'd3, 12'd1, 12'd1, 12'd1};
  localparam logic [47:0] BIG_H   = {12'd800, 12'd40, 12'd128, 12'd88};
  localparam logic [47:0] BIG_V   = {12'd600, 12'd1, 12'd4, 12'd23};

  task automatic check(input string tag, input int obs, input int exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_nf(input int limit, output int n);
    n = 0;
    while (nf_s !== 1'b1 && n < limit) begin
      step();
      n++;
    end
  endtask

  // Observe the small instance for len cycles, recording first-event indices.
  task automatic scan(input int len, output int nl1, output int nf1,
                      output int hsa, output int hsb, output int vsa, output int vsb,
                      output int rdy_hi, output int err_n);
    logic hs0, vs0;
    nl1 = -1; nf1 = -1; hsa = -1; hsb = -1; vsa = -1; vsb = -1; rdy_hi = 0; err_n = 0;
    hs0 = hsync_s;
    vs0 = vsync_s;
    for (int i = 0; i < len; i++) begin
      if (nl_s === 1'b1 && nl1 < 0) nl1 = i;
      if (nf_s === 1'b1 && nf1 < 0) nf1 = i;
      if (hsa < 0 && hsync_s !== hs0) hsa = i;
      else if (hsa >= 0 && hsb < 0 && hsync_s === hs0) hsb = i;
      if (vsa < 0 && vsync_s !== vs0) vsa = i;
      else if (vsa >= 0 && vsb < 0 && vsync_s === vs0) vsb = i;
      if (cfg_ready_s === 1'b1) rdy_hi++;
      if (cfg_err_s === 1'b1) err_n++;
      step();
    end
  endtask

  initial begin
    int fall, rise, nlat, bad, n;
    int nl1, nf1, hsa, hsb, vsa, vsb, rdy, errn;
    logic [11:0] x100;
    logic ha640;

    rst_d = 1'b1; en_d = 1'b0;
    rst_s = 1'b1; en_s = 1'b0; cfg_valid_s = 1'b0;
    cfg_h_s = SMALL_H; cfg_v_s = SMALL_V; cfg_pol_s = 2'b00;
    repeat (3) step();

    // Reset state of the default instance
    check("rst_hactive", int'(hactive_d), 1);
    check("rst_vactive", int'(vactive_d), 1);
    check("rst_de", int'(de_d), 1);
    check("rst_x", int'(x_d), 0);
    check("rst_y", int'(y_d), 0);
    check("rst_hsync", int'(hsync_d), 1);
    check("rst_vsync", int'(vsync_d), 1);
    check("rst_cfg_ready", int'(cfg_ready_d), 1);
    check("rst_cfg_err", int'(cfg_err_d), 0);
    check("rst_frame_count", int'(fc_d), 0);
    check("rst_next_line", int'(nl_d), 0);
    check("rst_next_frame", int'(nf_d), 0);

    // Default 800-clock line
    rst_d = 1'b0; en_d = 1'b1;
    fall = -1; rise = -1; nlat = -1; x100 = 12'd0; ha640 = 1'b1;
    for (int i = 0; i < 800; i++) begin
      if (hsync_d === 1'b0 && fall < 0) fall = i;
      if (hsync_d === 1'b1 && fall >= 0 && rise < 0) rise = i;
      if (nl_d === 1'b1 && nlat < 0) nlat = i;
      if (i == 100) x100 = x_d;
      if (i == 640) ha640 = hactive_d;
      step();
    end
    check("def_hsync_fall", fall, 656);
    check("def_hsync_rise", rise, 752);
    check("def_next_line", nlat, 799);
    check("def_x100", int'(x100), 100);
    check("def_hactive640", int'(ha640), 0);
    check("def_line2_x", int'(x_d), 0);
    check("def_line2_y", int'(y_d), 1);
    check("def_line2_vsync", int'(vsync_d), 1);

    // Enable toggling each clock doubles the line period
    nlat = -1; bad = 0;
    for (int c = 0; c < 1700; c++) begin
      en_d = (c % 2 == 0);
      #1;
      if (!en_d && (nl_d === 1'b1 || nf_d === 1'b1)) bad++;
      if (en_d && nl_d === 1'b1 && nlat < 0) nlat = c;
      @(posedge clk);
      #1;
    end
    en_d = 1'b1;
    check("toggle_next_line", nlat, 1598);
    check("toggle_pulse_while_idle", bad, 0);

    // Small instance: full frame timing
    rst_s = 1'b0; en_s = 1'b1;
    scan(128, nl1, nf1, hsa, hsb, vsa, vsb, rdy, errn);
    check("small_nl", nl1, 15);
    check("small_nf", nf1, 127);
    check("small_hs_start", hsa, 10);
    check("small_hs_end", hsb, 13);
    check("small_vs_start", vsa, 80);
    check("small_vs_end", vsb, 112);
    check("small_fc1", int'(fc_s), 1);
    repeat (256) step();
    check("small_fc3", int'(fc_s), 3);

    // Rejected offers: zero-length sync, oversize total
    cfg_h_s = BAD_H0; cfg_v_s = SMALL_V; cfg_valid_s = 1'b1;
    check("bad0_ready_before", int'(cfg_ready_s), 1);
    step();
    cfg_valid_s = 1'b0;
    check("bad0_err", int'(cfg_err_s), 1);
    check("bad0_ready", int'(cfg_ready_s), 1);
    step();
    check("bad0_err_clear", int'(cfg_err_s), 0);
    cfg_h_s = BAD_BIG; cfg_valid_s = 1'b1;
    step();
    cfg_valid_s = 1'b0;
    check("bigtot_err", int'(cfg_err_s), 1);
    step();
    check("bigtot_err_clear", int'(cfg_err_s), 0);
    check("bigtot_ready", int'(cfg_ready_s), 1);
    wait_nf(200, n);
    check("bad_timing_unchanged", n, 123);

    // Offer on the frame-end edge, then a stalled second offer
    cfg_h_s = MIN_A; cfg_v_s = MIN_A; cfg_pol_s = 2'b00; cfg_valid_s = 1'b1;
    step();
    cfg_h_s = B_H; cfg_v_s = B_V; cfg_pol_s = 2'b11;
    check("edge_ready_low", int'(cfg_ready_s), 0);
    scan(128, nl1, nf1, hsa, hsb, vsa, vsb, rdy, errn);
    check("edge_old_nl", nl1, 15);
    check("edge_old_nf", nf1, 127);
    check("edge_stall_ready", rdy, 0);
    check("edge_stall_err", errn, 0);
    check("edge_ready_after", int'(cfg_ready_s), 1);
    step();
    cfg_valid_s = 1'b0;
    check("second_pending", int'(cfg_ready_s), 0);
    scan(15, nl1, nf1, hsa, hsb, vsa, vsb, rdy, errn);
    check("min_nl", nl1, 2);
    check("min_nf", nf1, 14);
    check("min_hs_start", hsa, 1);
    check("min_hs_end", hsb, 2);
    check("min_vs_start", vsa, 7);
    check("min_vs_end", vsb, 11);
    check("b_ready", int'(cfg_ready_s), 1);
    scan(60, nl1, nf1, hsa, hsb, vsa, vsb, rdy, errn);
    check("b_nl", nl1, 9);
    check("b_nf", nf1, 59);
    check("b_hs_start", hsa, 7);
    check("b_hs_end", hsb, 9);
    check("b_vs_start", vsa, 40);
    check("b_vs_end", vsb, 50);
    check("b_fc", int'(fc_s), 7);

    // Mid-frame 800x600 offer with positive polarities
    repeat (5) step();
    cfg_h_s = BIG_H; cfg_v_s = BIG_V; cfg_pol_s = 2'b11; cfg_valid_s = 1'b1;
    step();
    cfg_valid_s = 1'b0;
    check("big_ready_low", int'(cfg_ready_s), 0);
    check("big_err", int'(cfg_err_s), 0);
    wait_nf(100, n);
    check("big_old_kept", n, 53);
    step();
    check("big_vsync_idle", int'(vsync_s), 0);
    check("big_hsync_idle", int'(hsync_s), 0);
    scan(1056, nl1, nf1, hsa, hsb, vsa, vsb, rdy, errn);
    check("big_nl", nl1, 1055);
    check("big_hs_start", hsa, 840);
    check("big_hs_end", hsb, 968);
    check("big_no_nf", nf1, -1);
    check("big_y1", int'(y_s), 1);

    // Async reset mid-line with a config pending
    cfg_h_s = B_H; cfg_v_s = B_V; cfg_valid_s = 1'b1;
    step();
    cfg_valid_s = 1'b0;
    check("pre_rst_pending", int'(cfg_ready_s), 0);
    repeat (299) step();
    check("pre_rst_x", int'(x_s), 300);
    rst_s = 1'b1;
    #1;
    check("rst_x_now", int'(x_s), 0);
    check("rst_y_now", int'(y_s), 0);
    check("rst_pending_clear", int'(cfg_ready_s), 1);
    check("rst_hsync_now", int'(hsync_s), 1);
    check("rst_vsync_now", int'(vsync_s), 1);
    check("rst_de_now", int'(de_s), 1);
    check("rst_fc_now", int'(fc_s), 0);
    step();
    rst_s = 1'b0;
    scan(128, nl1, nf1, hsa, hsb, vsa, vsb, rdy, errn);
    check("post_rst_nl", nl1, 15);
    check("post_rst_nf", nf1, 127);
    check("post_rst_hs_start", hsa, 10);
    check("post_rst_vs_start", vsa, 80);
    check("post_rst_fc", int'(fc_s), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Combined horizontal/vertical VGA timing generator: one block replaces a pair of cascaded single-axis sync generators.
- Timing is runtime-reprogrammable through a valid/ready config port. New timing takes effect only at a frame boundary.
- Outputs per-axis sync with programmable polarity, data-enable, pixel coordinates, line/frame pulses and a frame counter.
- Sits between the platform clock/reset and the pixel pipeline and connector pins.

Parameters:
- W, 12, width of all position/length fields.
- FCW, 16, width of frame_count.
- H_ACTIVE, 640, reset horizontal active length.
- H_FP, 16, reset horizontal front porch.
- H_SYNC, 96, reset horizontal sync length.
- H_BP, 48, reset horizontal back porch.
- V_ACTIVE, 480, reset vertical active length.
- V_FP, 10, reset vertical front porch.
- V_SYNC, 2, reset vertical sync length.
- V_BP, 33, reset vertical back porch.
- H_POL, 0, reset hsync polarity (0 = active-low pin).
- V_POL, 0, reset vsync polarity.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- enable  in  1  pixel-clock enable; position advances only when high.
- cfg_valid  in  1  new timing offered.
- cfg_ready  out  1  config slot free.
- cfg_h  in  4*W  {active, fp, sync, bp}, active in MSBs.
- cfg_v  in  4*W  {active, fp, sync, bp}, active in MSBs.
- cfg_pol  in  2  {vpol, hpol}.
- cfg_err  out  1  one-cycle pulse: offered config rejected.
- hsync  out  1  horizontal sync pin level, polarity applied.
- vsync  out  1  vertical sync pin level, polarity applied.
- hactive  out  1  horizontal active region.
- vactive  out  1  vertical active region.
- de  out  1  hactive & vactive.
- x  out  W  hpos when hactive, else 0.
- y  out  W  vpos when vactive, else 0.
- next_line  out  1  enable & last pixel of line.
- next_frame  out  1  enable & last pixel of frame.
- frame_count  out  FCW  completed frames, wraps.

Behaviour:
- State: hpos, vpos (W bits), live timing set, shadow timing set, pending flag, frame_count.
- All status outputs decode combinationally from registered state. No added latency.
- Line layout: active, then fp, then sync, then bp. htot = active+fp+sync+bp, computed in W+2 bits.
- hactive = hpos < h_active.
- Horizontal sync asserted while h_active+h_fp <= hpos < h_active+h_fp+h_sync. Pin level = asserted XOR ~hpol, so hpol=0 drives the pin low while asserted.
- Vertical decode is identical using vpos and the v fields.
- Advance on enable=1:
  - hpos increments; at hpos == htot-1 it wraps to 0 and vpos increments.
  - vpos wraps to 0 at vtot-1.
  - enable=0: all state holds; next_line and next_frame are 0.
- next_frame cycle (enable & hpos==htot-1 & vpos==vtot-1):
  - frame_count increments.
  - If pending, live <= shadow and pending clears in the same edge, so pixel (0,0) of the next frame uses the new timing.
- Config handshake: cfg_ready = ~pending.
  - Transfer on cfg_valid & cfg_ready.
  - Any length field == 0, or htot/vtot > 2^W: no transfer effect; cfg_err pulses for 1 cycle.
  - Otherwise fields go to shadow and pending sets.
- Transfer coinciding with a next_frame edge while not pending: shadow is loaded and pending sets. Live timing is not updated until the following frame end; there is no bypass.
- While pending, further offers stall (cfg_ready=0). cfg_err never fires for a stalled offer.
- Reset (async, any time, including mid-frame or with a config pending):
  - hpos=vpos=0, frame_count=0, pending=0.
  - Live and shadow timing = parameters.
  - cfg_err=0.
  - Outputs therefore show hactive=vactive=de=1, x=y=0, hsync=vsync=1 for default polarities.
- Minimum legal timing is 1 per field (htot=4). Sync in the last position must still wrap correctly.

Test Plan:
- Reset defaults, enable=1 constant: next_line period 800 clks. Per line, hsync low during hpos 656..751; vsync low for vpos 490..491; next_frame every 420000 clks; frame_count=3 after 1260000 clks.
- enable toggling 1/0 each clk: all periods double (next_line every 1600 clks); next_line/next_frame never high while enable=0.
- Mid-frame config 800/40/128/88, 600/1/4/23, pol=2'b11: cfg_ready drops, old timing is kept to frame end. The next frame has next_line period 1056, hsync high at hpos 840..967, and vtot 628.
- Config with h_sync=0: cfg_err pulses 1 cycle, cfg_ready stays 1, timing unchanged.
- Config offered exactly on the next_frame edge, then a second offer: the first applies one frame later; the second stalls with cfg_ready=0 until that frame end.
- Assert rst at hpos=300, vpos=200 with a config pending: x=y=0 immediately; pending cleared; the next frame uses default 640x480 timing.
